// File: rtl/count_end_period_monitor_if.sv
// count_end_period_monitor_if: control inputs and measurement outputs of the period monitor.
interface count_end_period_monitor_if #(parameter int CNT_W = 8);
  logic             i_enable;
  logic             i_count_end;
  logic             i_err_clr;
  logic [CNT_W-1:0] o_period;
  logic             o_period_valid;
  logic             o_locked;
  logic             o_err_pulse;
  logic             o_timeout;
  logic [7:0]       o_err_count;
  modport master (output i_enable, i_count_end, i_err_clr,
                  input  o_period, o_period_valid, o_locked, o_err_pulse, o_timeout, o_err_count);
  modport slave  (input  i_enable, i_count_end, i_err_clr,
                  output o_period, o_period_valid, o_locked, o_err_pulse, o_timeout, o_err_count);
endinterface

// File: rtl/count_end_period_monitor.sv
// count_end_period_monitor: measures count-end pulse spacing, tracks lock, flags period errors and timeouts.
module count_end_period_monitor #(
  parameter int EXP_PERIOD = 8,
  parameter int TOL        = 0,
  parameter int LOCK_CNT   = 4,
  parameter int CNT_W      = 8
) (
  input logic clk,
  input logic resetn,
  count_end_period_monitor_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACQUIRE, MEASURE, LOCKED} state_t;
  localparam logic [CNT_W-1:0] EXP_L  = CNT_W'(EXP_PERIOD);
  localparam logic [CNT_W-1:0] TOL_L  = CNT_W'(TOL);
  localparam logic [CNT_W-1:0] TMO_L  = CNT_W'(2 * EXP_PERIOD);
  localparam logic [3:0]       LOCK_L = 4'(LOCK_CNT);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, period_q, period_d, diff;
  logic [3:0]       match_q, match_d;
  logic [7:0]       err_count_q, err_count_d;
  logic             period_valid_q, period_valid_d, locked_q, locked_d;
  logic             err_pulse_q, err_pulse_d, timeout_q, timeout_d, err_inc, in_tol;
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    match_d        = match_q;
    period_d       = period_q;
    period_valid_d = 1'b0;
    locked_d       = locked_q;
    err_pulse_d    = 1'b0;
    timeout_d      = 1'b0;
    err_inc        = 1'b0;
    diff           = (cnt_q > EXP_L) ? cnt_q - EXP_L : EXP_L - cnt_q;
    in_tol         = diff <= TOL_L;
    if (!bus.i_enable) begin
      state_d  = IDLE;
      cnt_d    = '0;
      match_d  = '0;
      locked_d = 1'b0;
    end else begin
      case (state_q)
        IDLE:    state_d = ACQUIRE;
        ACQUIRE: if (bus.i_count_end) begin
          cnt_d   = CNT_W'(1);
          state_d = MEASURE;
        end
        default: begin
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
          if (bus.i_count_end) begin
            period_d       = cnt_q;
            period_valid_d = 1'b1;
            cnt_d          = CNT_W'(1);
            if (!in_tol) begin
              err_pulse_d = 1'b1;
              err_inc     = 1'b1;
              match_d     = '0;
              locked_d    = 1'b0;
              state_d     = MEASURE;
            end else if (state_q == MEASURE) begin
              match_d = match_q + 4'd1;
              if (match_d == LOCK_L) begin
                state_d  = LOCKED;
                locked_d = 1'b1;
              end
            end
          end else if (cnt_q >= TMO_L) begin
            // a pulse landing on the limit cycle is a measurement, so only an empty cycle times out
            timeout_d   = 1'b1;
            err_pulse_d = 1'b1;
            err_inc     = 1'b1;
            match_d     = '0;
            locked_d    = 1'b0;
            cnt_d       = '0;
            state_d     = ACQUIRE;
          end
        end
      endcase
    end
    err_count_d = bus.i_err_clr ? 8'd0 :
                  (err_inc && err_count_q != 8'hff) ? err_count_q + 8'd1 : err_count_q;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      match_q        <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      err_pulse_q    <= 1'b0;
      timeout_q      <= 1'b0;
      err_count_q    <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      match_q        <= match_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      locked_q       <= locked_d;
      err_pulse_q    <= err_pulse_d;
      timeout_q      <= timeout_d;
      err_count_q    <= err_count_d;
    end
  end
  assign bus.o_period       = period_q;
  assign bus.o_period_valid = period_valid_q;
  assign bus.o_locked       = locked_q;
  assign bus.o_err_pulse    = err_pulse_q;
  assign bus.o_timeout      = timeout_q;
  assign bus.o_err_count    = err_count_q;
endmodule

// File: tb/tb_count_end_period_monitor.sv
// tb_count_end_period_monitor: directed scenarios for lock, stall errors, timeout, saturation, disable and reset.
module tb_count_end_period_monitor;
  logic clk, resetn;
  int vec, miss, since;
  count_end_period_monitor_if #(.CNT_W(8)) b ();
  count_end_period_monitor dut (.clk(clk), .resetn(resetn), .bus(b));
  logic [19:0] obs;
  assign obs = {b.o_period, b.o_period_valid, b.o_locked, b.o_err_pulse, b.o_timeout, b.o_err_count};
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [19:0] ev(input int p, input bit v, l, e, t, input int c);
    return {8'(p), v, l, e, t, 8'(c)};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
    since++;
  endtask
  task automatic gap_pulse(input int g);
    b.i_count_end = 1'b0;
    while (since < g - 1) tick();
    b.i_count_end = 1'b1;
    tick();
    b.i_count_end = 1'b0;
    since = 0;
  endtask
  task automatic test_reset();
    resetn = 1'b0;
    for (int i = 0; i < 10; i++) begin
      b.i_enable = 1'($urandom); b.i_count_end = 1'($urandom); b.i_err_clr = 1'($urandom);
      tick();
      if (obs !== 20'd0) begin $display("FAIL reset_hold_%0d: got %h want %h", i, obs, 20'd0); miss++; end
      vec++;
    end
    b.i_enable = 1'b1; b.i_count_end = 1'b1; b.i_err_clr = 1'b0;
    resetn = 1'b1;
    tick();
    b.i_count_end = 1'b0;
    since = 0;
    if (obs !== 20'd0) begin $display("FAIL reset_release: got %h want %h", obs, 20'd0); miss++; end
    vec++;
  endtask
  task automatic lock_up(input string nm, input int ec);
    gap_pulse(3);
    if (obs !== ev(0, 0, 0, 0, 0, ec) && obs !== ev(8, 0, 0, 0, 0, ec)) begin
      $display("FAIL %s_acquire: got %h want no period strobe", nm, obs); miss++;
    end
    vec++;
    for (int i = 1; i <= 4; i++) begin
      gap_pulse(8);
      if (obs !== ev(8, 1, i == 4, 0, 0, ec)) begin
        $display("FAIL %s_period_%0d: got %h want %h", nm, i, obs, ev(8, 1, i == 4, 0, 0, ec)); miss++;
      end
      vec++;
    end
  endtask
  task automatic test_lock();
    lock_up("lock", 0);
    tick();
    if (obs !== ev(8, 0, 1, 0, 0, 0)) begin $display("FAIL lock_hold: got %h want %h", obs, ev(8, 0, 1, 0, 0, 0)); miss++; end
    vec++;
  endtask
  task automatic test_stall();
    gap_pulse(12);
    if (obs !== ev(12, 1, 0, 1, 0, 1)) begin $display("FAIL stall_err: got %h want %h", obs, ev(12, 1, 0, 1, 0, 1)); miss++; end
    vec++;
    for (int i = 1; i <= 4; i++) begin
      gap_pulse(8);
      if (obs !== ev(8, 1, i == 4, 0, 0, 1)) begin
        $display("FAIL stall_relock_%0d: got %h want %h", i, obs, ev(8, 1, i == 4, 0, 0, 1)); miss++;
      end
      vec++;
    end
  endtask
  task automatic test_timeout();
    b.i_count_end = 1'b0;
    while (since < 15) tick();
    if (obs !== ev(8, 0, 1, 0, 0, 1)) begin $display("FAIL timeout_early: got %h want %h", obs, ev(8, 0, 1, 0, 0, 1)); miss++; end
    vec++;
    tick();
    if (obs !== ev(8, 0, 0, 1, 1, 2)) begin $display("FAIL timeout_fire: got %h want %h", obs, ev(8, 0, 0, 1, 1, 2)); miss++; end
    vec++;
    since = 0;
    gap_pulse(5);
    if (obs !== ev(8, 0, 0, 0, 0, 2)) begin $display("FAIL timeout_reacquire: got %h want %h", obs, ev(8, 0, 0, 0, 0, 2)); miss++; end
    vec++;
    gap_pulse(8);
    if (obs !== ev(8, 1, 0, 0, 0, 2)) begin $display("FAIL timeout_measure: got %h want %h", obs, ev(8, 1, 0, 0, 0, 2)); miss++; end
    vec++;
  endtask
  task automatic test_saturation();
    b.i_count_end = 1'b1;
    for (int i = 1; i <= 260; i++) begin
      tick();
      if (i == 252 && obs !== ev(1, 1, 0, 1, 0, 254)) begin
        $display("FAIL sat_254: got %h want %h", obs, ev(1, 1, 0, 1, 0, 254)); miss++;
      end
    end
    vec++;
    if (obs !== ev(1, 1, 0, 1, 0, 255)) begin $display("FAIL sat_255: got %h want %h", obs, ev(1, 1, 0, 1, 0, 255)); miss++; end
    vec++;
    b.i_err_clr = 1'b1;
    tick();
    b.i_err_clr = 1'b0;
    b.i_count_end = 1'b0;
    since = 0;
    if (obs !== ev(1, 1, 0, 1, 0, 0)) begin $display("FAIL clr_priority: got %h want %h", obs, ev(1, 1, 0, 1, 0, 0)); miss++; end
    vec++;
  endtask
  task automatic test_disable_reset();
    gap_pulse(10);
    if (obs !== ev(10, 1, 0, 1, 0, 1)) begin $display("FAIL dis_err: got %h want %h", obs, ev(10, 1, 0, 1, 0, 1)); miss++; end
    vec++;
    for (int i = 1; i <= 4; i++) gap_pulse(8);
    if (obs !== ev(8, 1, 1, 0, 0, 1)) begin $display("FAIL dis_locked: got %h want %h", obs, ev(8, 1, 1, 0, 0, 1)); miss++; end
    vec++;
    b.i_enable = 1'b0;
    tick();
    if (obs !== ev(8, 0, 0, 0, 0, 1)) begin $display("FAIL dis_unlock: got %h want %h", obs, ev(8, 0, 0, 0, 0, 1)); miss++; end
    vec++;
    b.i_count_end = 1'b1;
    tick();
    b.i_count_end = 1'b0;
    if (obs !== ev(8, 0, 0, 0, 0, 1)) begin $display("FAIL dis_idle_pulse: got %h want %h", obs, ev(8, 0, 0, 0, 0, 1)); miss++; end
    vec++;
    b.i_enable = 1'b1;
    tick();
    lock_up("relock", 1);
    tick(); tick(); tick();
    #2;
    resetn = 1'b0;
    #1;
    if (obs !== 20'd0) begin $display("FAIL async_reset: got %h want %h", obs, 20'd0); miss++; end
    vec++;
    tick();
    resetn = 1'b1;
    tick();
    if (obs !== 20'd0) begin $display("FAIL post_reset: got %h want %h", obs, 20'd0); miss++; end
    vec++;
  endtask
  initial begin
    vec = 0; miss = 0; since = 0;
    resetn = 1'b0;
    b.i_enable = 1'b0; b.i_count_end = 1'b0; b.i_err_clr = 1'b0;
    test_reset();
    test_lock();
    test_stall();
    test_timeout();
    test_saturation();
    test_disable_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
